multicycle_ctrl: RTL and testbench

//  Moore-style control FSM for the multi-cycle MIPS datapath. Sequences fetch, decode, execute,

---
 rtl/mc_pkg.sv | 65 ++++++
 rtl/mc_out_decode.sv | 78 +++++++
 rtl/multicycle_ctrl.sv | 134 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Optional macro MC_ADDI_EN adds the addi execute/write-back states.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_HALT     = 4'd10
`ifdef MC_ADDI_EN
        ,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that stall on the memory handshake and feed the wait counter.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Moore control-word decoder: maps the current FSM state to datapath controls.
// Fetch-side IRWrite/PCWrite are qualified by mem_ready. Honours MC_ADDI_EN.
module mc_out_decode
    import mc_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target: PC + (imm << 2) into ALUOut.
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready stall, wait timeout and sticky fault.
// Define MC_ADDI_EN to support addi (opcode 001000); otherwise it decodes as illegal.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic       mem_timeout
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
    logic             timeout_hit;
    logic             illegal_d;
    logic             wait_limit;
    ctrl_t            ctrl_d, ctrl_o;

    // Zero is applied by the datapath's PCWriteCond gate, not by the sequencer.
    logic unused_zero;
    assign unused_zero = Zero;

    assign wait_limit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (is_wait_state(state_q) && !mem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                // A completing access on the limit cycle takes priority over the fault.
                if (mem_ready) begin
                    case (state_q)
                        S_FETCH:  state_d = S_DECODE;
                        S_MEM_RD: state_d = S_MEM_WB;
                        default:  state_d = S_FETCH;
                    endcase
                end else if (wait_limit) begin
                    state_d     = S_HALT;
                    timeout_hit = 1'b1;
                end
            end
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_EXEC:     state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
`endif
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    mc_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_d)
    );

    // Reset masks the control word combinationally so in-flight requests drop at once.
    assign ctrl_o = reset ? '0 : ctrl_d;

    assign PCWrite     = ctrl_o.pc_write;
    assign PCWriteCond = ctrl_o.pc_write_cond;
    assign IorD        = ctrl_o.iord;
    assign MemRead     = ctrl_o.mem_read;
    assign MemWrite    = ctrl_o.mem_write;
    assign IRWrite     = ctrl_o.ir_write;
    assign MemToReg    = ctrl_o.mem_to_reg;
    assign RegDst      = ctrl_o.reg_dst;
    assign RegWrite    = ctrl_o.reg_write;
    assign ALUSrcA     = ctrl_o.alu_src_a;
    assign ALUSrcB     = ctrl_o.alu_src_b;
    assign ALUOp       = ctrl_o.alu_op;
    assign PCSource    = ctrl_o.pc_source;
    assign illegal_op  = illegal_d & ~reset;
    assign mem_timeout = timeout_q & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl; one vector per clock cycle plus an async-reset sequence.
// Honours MC_ADDI_EN the same way as the design.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'b000000;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, ALUSrcA, illegal_op, mem_timeout;
    logic [1:0] ALUSrcB, ALUOp, PCSource;

    multicycle_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .Zero        (Zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemToReg    (MemToReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010, RT = 6'b000000, ADDI = 6'b001000, BAD = 6'b111111;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [17:0] act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, mem_timeout};

    function automatic logic [17:0] cw(input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw,
                                       sa, input logic [1:0] sb, aop, ps, input logic ill, tmo);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, ill, tmo};
    endfunction

    task automatic add(input string n, input logic r, input logic [5:0] o, input logic z,
                       input logic rd, input logic [17:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.op = o; v.zero = z; v.rdy = rd; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [17:0] a, input logic [17:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", n, a, e);
        end
    endtask

    logic [17:0] E_ZERO, E_FW, E_FR, E_DEC, E_DILL, E_MADR, E_MRD, E_MWB, E_MWR;
    logic [17:0] E_EXEC, E_AWB, E_BR, E_JMP, E_HALT, E_AEX, E_AWB0;

    initial begin
        E_ZERO = '0;
        E_FW   = cw(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
        E_FR   = cw(1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
        E_DEC  = cw(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
        E_DILL = cw(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 1,0);
        E_MADR = cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
        E_MRD  = cw(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        E_MWB  = cw(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0,0);
        E_MWR  = cw(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
        E_EXEC = cw(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0);
        E_AWB  = cw(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 0,0);
        E_BR   = cw(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0,0);
        E_JMP  = cw(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 0,0);
        E_HALT = cw(0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,1);
        E_AEX  = cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
        E_AWB0 = cw(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0,0);

        add("reset_hold", 1, RT,  0, 1, E_ZERO);
        add("r_fetch",    0, RT,  0, 1, E_FR);
        add("r_decode",   0, RT,  0, 1, E_DEC);
        add("r_exec",     0, RT,  0, 1, E_EXEC);
        add("r_alu_wb",   0, RT,  0, 1, E_AWB);
        add("lw_fetch",   0, LW,  0, 1, E_FR);
        add("lw_decode",  0, LW,  0, 1, E_DEC);
        add("lw_addr",    0, LW,  0, 1, E_MADR);
        for (int i = 0; i < 3; i++) add("lw_rd_wait", 0, LW, 0, 0, E_MRD);
        add("lw_rd_done", 0, LW,  0, 1, E_MRD);
        add("lw_wb",      0, LW,  0, 1, E_MWB);
        add("beq_fetch",  0, BEQ, 1, 1, E_FR);
        add("beq_decode", 0, BEQ, 1, 1, E_DEC);
        add("beq_branch", 0, BEQ, 1, 1, E_BR);
        add("ill_fetch",  0, BAD, 0, 1, E_FR);
        add("ill_decode", 0, BAD, 0, 1, E_DILL);
        add("j_fetch_w",  0, JMP, 0, 0, E_FW);
        add("j_fetch",    0, JMP, 0, 1, E_FR);
        add("j_decode",   0, JMP, 0, 1, E_DEC);
        add("j_jump",     0, JMP, 0, 1, E_JMP);
        add("sw_fetch",   0, SW,  0, 1, E_FR);
        add("sw_decode",  0, SW,  0, 1, E_DEC);
        add("sw_addr",    0, SW,  0, 1, E_MADR);
        add("sw_wr",      0, SW,  0, 1, E_MWR);
        add("addi_fetch", 0, ADDI, 0, 1, E_FR);
`ifdef MC_ADDI_EN
        add("addi_decode", 0, ADDI, 0, 1, E_DEC);
        add("addi_ex",     0, ADDI, 0, 1, E_AEX);
        add("addi_wb",     0, ADDI, 0, 1, E_AWB0);
`else
        add("addi_illegal", 0, ADDI, 0, 1, E_DILL);
`endif
        // 15 stalled fetch cycles, ready on the 16th: no fault.
        for (int i = 0; i < 15; i++) add("nf_wait", 0, RT, 0, 0, E_FW);
        add("nf_fetch",   0, RT,  0, 1, E_FR);
        add("nf_decode",  0, RT,  0, 1, E_DEC);
        add("nf_exec",    0, RT,  0, 1, E_EXEC);
        add("nf_alu_wb",  0, RT,  0, 1, E_AWB);
        // 16 stalled fetch cycles: fault and halt, regardless of later ready.
        for (int i = 0; i < 16; i++) add("to_wait", 0, RT, 0, 0, E_FW);
        for (int i = 0; i < 3; i++) add("halt", 0, RT, 0, 1, E_HALT);
        add("reset_clr",  1, SW,  0, 1, E_ZERO);
        add("sw2_fetch",  0, SW,  0, 1, E_FR);
        add("sw2_decode", 0, SW,  0, 1, E_DEC);
        add("sw2_addr",   0, SW,  0, 1, E_MADR);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            Opcode = vecs[i].op;
            Zero = vecs[i].zero;
            mem_ready = vecs[i].rdy;
            #2;
            check(vecs[i].name, act, vecs[i].exp);
        end

        // Reset arrives mid-cycle during a stalled write: request must drop immediately.
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        check("sw2_wr_stall", act, E_MWR);
        #1 reset = 1'b1;
        #1;
        check("async_rst_outputs", act, E_ZERO);
        n_chk++;
        if (MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_memwrite: got %b, expected 0", MemWrite);
        end
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("post_rst_fetch", act, E_FW);
        @(negedge clk);
        mem_ready = 1'b1;
        Opcode = RT;
        #2;
        check("post_rst_fetch_rdy", act, E_FR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
